// File: rtl/jts18_vdp_mix.sv
// jts18_vdp_mix: final colour mixer between the System-16 palette and the VDP.
// Two-stage pixel pipeline (capture on pxl_cen, select one clk later with vdp_sel)
// plus a frame-synchronised latch for the CPU-written VDP priority code.
// Optional debug overrides are compiled in with the macro JTS18_MIXDBG_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | vdp_prio is up to date, no CPU write waiting
// PENDING | a CPU write sits in shadow, applied at the next vblank start
module jts18_vdp_mix #(
  parameter logic [2:0]  PRIO_RST  = 3'd0,
  parameter logic [14:0] BLANK_RGB = 15'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pxl_cen,
  input  logic [7:0]  debug_bus,
  input  logic        prio_we,
  input  logic [2:0]  prio_din,
  output logic [2:0]  vdp_prio,
  input  logic        vdp_en,
  input  logic        vdp_sel,
  input  logic [14:0] s16_rgb,
  input  logic [8:0]  vdp_rgb,
  input  logic        hs,
  input  logic        vs,
  input  logic        lhbl,
  input  logic        lvbl,
  output logic [4:0]  red,
  output logic [4:0]  green,
  output logic [4:0]  blue,
  output logic        hs_o,
  output logic        vs_o,
  output logic        lhbl_o,
  output logic        lvbl_o
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} prio_st_t;

  logic [14:0] s16_a;
  logic [8:0]  vdp_a;
  logic        hs_a, vs_a, lhbl_a, lvbl_a;
  logic        cen_d;

  logic        blank;
  logic        use_vdp;
  logic [14:0] vdp_exp;
  logic [14:0] rgb_nx;

  prio_st_t    st, st_nx;
  logic [2:0]  shadow, shadow_nx;
  logic [2:0]  prio_nx;
  logic        lvbl_l;
  logic        vb_start;
  logic        prio_bypass;

  // 3-bit channel to 5 bits by repeating the top bits into the LSBs
  function automatic logic [4:0] expand(input logic [2:0] c);
    return {c, c[2:1]};
  endfunction

`ifdef JTS18_MIXDBG_EN
  assign use_vdp     = !debug_bus[0] && (debug_bus[1] || (vdp_en && vdp_sel));
  assign prio_bypass = debug_bus[7];
`else
  logic unused_dbg;
  assign unused_dbg  = ^debug_bus;
  assign use_vdp     = vdp_en && vdp_sel;
  assign prio_bypass = 1'b0;
`endif

  assign blank    = !(lhbl_a && lvbl_a);
  assign vdp_exp  = {expand(vdp_a[8:6]), expand(vdp_a[5:3]), expand(vdp_a[2:0])};
  assign vb_start = lvbl_l && !lvbl;

  // Colour selection for the pixel held in stage A
  always_comb begin
    rgb_nx = s16_a;
    if (blank)        rgb_nx = BLANK_RGB;
    else if (use_vdp) rgb_nx = vdp_exp;
  end

  // Stage A: capture the pixel and its sync/blank on the pixel enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s16_a  <= '0;
      vdp_a  <= '0;
      hs_a   <= 1'b0;
      vs_a   <= 1'b0;
      lhbl_a <= 1'b0;
      lvbl_a <= 1'b0;
      cen_d  <= 1'b0;
    end else begin
      cen_d <= pxl_cen;
      if (pxl_cen) begin
        s16_a  <= s16_rgb;
        vdp_a  <= vdp_rgb;
        hs_a   <= hs;
        vs_a   <= vs;
        lhbl_a <= lhbl;
        lvbl_a <= lvbl;
      end
    end
  end

  // Stage B: one clk after capture, when vdp_sel describes the captured pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red    <= '0;
      green  <= '0;
      blue   <= '0;
      hs_o   <= 1'b0;
      vs_o   <= 1'b0;
      lhbl_o <= 1'b0;
      lvbl_o <= 1'b0;
    end else if (cen_d) begin
      {red, green, blue} <= rgb_nx;
      hs_o   <= hs_a;
      vs_o   <= vs_a;
      lhbl_o <= lhbl_a;
      lvbl_o <= lvbl_a;
    end
  end

  // Priority latch registers and vblank edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      shadow   <= PRIO_RST;
      vdp_prio <= PRIO_RST;
      lvbl_l   <= 1'b0;
    end else begin
      st       <= st_nx;
      shadow   <= shadow_nx;
      vdp_prio <= prio_nx;
      lvbl_l   <= lvbl;
    end
  end

  // Priority latch next state: a write on the vblank edge itself goes straight through
  always_comb begin
    st_nx     = st;
    shadow_nx = shadow;
    prio_nx   = vdp_prio;
    if (prio_we && (vb_start || prio_bypass)) begin
      prio_nx = prio_din;
      st_nx   = IDLE;
    end else if (prio_we) begin
      shadow_nx = prio_din;
      st_nx     = PENDING;
    end else if (vb_start && st == PENDING) begin
      prio_nx = shadow;
      st_nx   = IDLE;
    end
  end

endmodule

// File: tb/tb_jts18_vdp_mix.sv
// Bench for jts18_vdp_mix (default build, debug overrides compiled out).
module tb_jts18_vdp_mix;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pxl_cen;
  logic [7:0]  debug_bus;
  logic        prio_we;
  logic [2:0]  prio_din;
  logic [2:0]  vdp_prio;
  logic        vdp_en;
  logic        vdp_sel;
  logic [14:0] s16_rgb;
  logic [8:0]  vdp_rgb;
  logic        hs, vs, lhbl, lvbl;
  logic [4:0]  red, green, blue;
  logic        hs_o, vs_o, lhbl_o, lvbl_o;

  int tests = 0;
  int fails = 0;
  logic [18:0] prev_exp;

  jts18_vdp_mix dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .debug_bus(debug_bus),
    .prio_we(prio_we), .prio_din(prio_din), .vdp_prio(vdp_prio),
    .vdp_en(vdp_en), .vdp_sel(vdp_sel), .s16_rgb(s16_rgb), .vdp_rgb(vdp_rgb),
    .hs(hs), .vs(vs), .lhbl(lhbl), .lvbl(lvbl),
    .red(red), .green(green), .blue(blue),
    .hs_o(hs_o), .vs_o(vs_o), .lhbl_o(lhbl_o), .lvbl_o(lvbl_o)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] observed();
    return {red, green, blue, hs_o, vs_o, lhbl_o, lvbl_o};
  endfunction

  // 3-bit level scaled to 5 bits: c*4 plus the top two bits of c
  function automatic logic [4:0] scale3(input int c);
    return 5'(c * 4 + c / 2);
  endfunction

  // Reference: what the mixer must show for one pixel
  function automatic logic [18:0] model(input logic [14:0] s, input logic [8:0] v,
                                         input logic sel, input logic en,
                                         input logic h, input logic vv,
                                         input logic hb, input logic vb);
    logic [14:0] rgb;
    if (!(hb && vb))     rgb = 15'd0;
    else if (en && sel)  rgb = {scale3(int'(v[8:6])), scale3(int'(v[5:3])), scale3(int'(v[2:0]))};
    else                 rgb = s;
    return {rgb, h, vv, hb, vb};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One pixel every 4 clk: capture on edge N, result visible after edge N+1
  task automatic pixel(input string tag, input logic [14:0] s, input logic [8:0] v,
                       input logic sel, input logic en, input logic h, input logic vv,
                       input logic hb, input logic vb);
    logic [18:0] exp;
    exp = model(s, v, sel, en, h, vv, hb, vb);
    @(negedge clk);
    s16_rgb = s; vdp_rgb = v; vdp_sel = sel; vdp_en = en;
    hs = h; vs = vv; lhbl = hb; lvbl = vb; pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    s16_rgb = 15'($urandom); vdp_rgb = 9'($urandom);
    hs = 1'($urandom); vs = 1'($urandom); lhbl = 1'($urandom);
    check({tag, "_hold"}, 32'(observed()), 32'(prev_exp));
    @(negedge clk);
    check(tag, 32'(observed()), 32'(exp));
    prev_exp = exp;
    @(negedge clk);
  endtask

  task automatic write_prio(input logic [2:0] d);
    @(negedge clk);
    prio_we = 1'b1; prio_din = d;
    @(negedge clk);
    prio_we = 1'b0;
  endtask

  task automatic vblank_pulse();
    @(negedge clk); lvbl = 1'b0;
    @(negedge clk);
    @(negedge clk); lvbl = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; pxl_cen = 1'b0; debug_bus = 8'h00; prio_we = 1'b0; prio_din = 3'd0;
    vdp_en = 1'b0; vdp_sel = 1'b0; s16_rgb = '0; vdp_rgb = '0;
    hs = 1'b0; vs = 1'b0; lhbl = 1'b1; lvbl = 1'b1;
    prev_exp = '0;
    repeat (3) @(negedge clk);
    check("rst_out", 32'(observed()), 32'd0);
    check("rst_prio", 32'(vdp_prio), 32'd0);
    rst_n = 1'b1;

    // directed pixels
    pixel("vdp_742", 15'h1234, 9'o742, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("vdp_742_rgb", 32'({red, green, blue}), 32'({5'd31, 5'd18, 5'd9}));
    pixel("s16_7c1f", 15'h7C1F, 9'o777, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    pixel("vdp_777", 15'h0000, 9'o777, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    pixel("vdp_000", 15'h7FFF, 9'o000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    pixel("hblank", 15'h5555, 9'o742, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pixel("vblank_pix", 15'h2AAA, 9'o123, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    pixel("vdp_en0", 15'h3C3C, 9'o777, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // randomized pixels against the reference
    for (int i = 0; i < 40; i++) begin
      pixel("rand", 15'($urandom), 9'($urandom), 1'($urandom), 1'($urandom_range(3) != 0),
            1'($urandom), 1'($urandom), 1'($urandom_range(4) != 0), 1'b1);
    end

    // mid-line reset clears the pipeline and outputs
    pixel("pre_rst", 15'h7FFF, 9'o000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(observed()), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    prev_exp = '0;
    pixel("post_rst", 15'h0F0F, 9'o321, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

    // priority write is held until vblank start
    lvbl = 1'b1;
    write_prio(3'd5);
    repeat (3) @(negedge clk);
    check("prio_held", 32'(vdp_prio), 32'd0);
    @(negedge clk); lvbl = 1'b0;
    @(negedge clk);
    check("prio_vb", 32'(vdp_prio), 32'd5);
    @(negedge clk); lvbl = 1'b1;

    // last write in a frame wins
    write_prio(3'd2);
    write_prio(3'd6);
    check("prio_multi_held", 32'(vdp_prio), 32'd5);
    vblank_pulse();
    check("prio_last_wins", 32'(vdp_prio), 32'd6);

    // no write: vblank leaves the code alone
    vblank_pulse();
    check("prio_idle_vb", 32'(vdp_prio), 32'd6);

    // write on the vblank-start clk takes effect that edge, latch ends idle
    write_prio(3'd4);
    @(negedge clk);
    lvbl = 1'b0; prio_we = 1'b1; prio_din = 3'd3;
    @(negedge clk);
    prio_we = 1'b0;
    check("prio_collide", 32'(vdp_prio), 32'd3);
    @(negedge clk); lvbl = 1'b1;
    vblank_pulse();
    check("prio_collide_idle", 32'(vdp_prio), 32'd3);

    // reset discards a pending write
    write_prio(3'd7);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("prio_rst", 32'(vdp_prio), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    vblank_pulse();
    check("prio_rst_discard", 32'(vdp_prio), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
